// File: rtl/spi_frame_receiver.sv
// spi_frame_receiver: receives framed multi-channel SPI words and queues them, channel-tagged, in a ready/valid FIFO.
module spi_frame_receiver #(
  parameter int DATA_W     = 16,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int MSB_FIRST  = 1,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              serial_clk,
  input  logic              reset,
  input  logic              chip_select,
  input  logic              mosi,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] shift_reg_out,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              frame_done,
  output logic              frame_err,
  output logic              overflow
);
  localparam int BW = $clog2(DATA_W);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_W + CH_W;
  typedef enum logic [1:0] {S_WAIT, S_IDLE, S_RECV, S_DONE} state_t;
  state_t state, state_nxt;
  logic [DATA_W-1:0] shift_reg, shift_nxt;
  logic [BW-1:0] bit_cnt;
  logic [CH_W-1:0] ch_cnt;
  logic shift_en, word_end, last_ch, done_nxt, err_nxt;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic full, pop, wr_en;
  always_ff @(posedge serial_clk or negedge reset)
    if (!reset) state <= S_WAIT;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:  state_nxt = chip_select ? S_IDLE : S_WAIT;
      S_IDLE:  state_nxt = chip_select ? S_IDLE : S_RECV;
      S_RECV:  state_nxt = chip_select ? S_IDLE : (word_end && last_ch) ? S_DONE : S_RECV;
      S_DONE:  state_nxt = chip_select ? S_IDLE : S_DONE;
      default: state_nxt = S_WAIT;
    endcase
  end
  // IDLE captures the first bit exactly like a RECV shift from a cleared register
  always_comb begin
    shift_en  = !chip_select && (state == S_IDLE || state == S_RECV);
    word_end  = shift_en && bit_cnt == BW'(DATA_W - 1);
    last_ch   = ch_cnt == CH_W'(NUM_CH - 1);
    done_nxt  = chip_select && state == S_DONE;
    err_nxt   = chip_select && state == S_RECV && (bit_cnt != '0 || ch_cnt != '0);
    shift_nxt = (MSB_FIRST != 0) ? {shift_reg[DATA_W-2:0], mosi} : {mosi, shift_reg[DATA_W-1:1]};
  end
  always_ff @(posedge serial_clk or negedge reset)
    if (!reset) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      ch_cnt     <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= done_nxt;
      frame_err  <= err_nxt;
      if (chip_select) begin
        shift_reg <= '0;
        bit_cnt   <= '0;
        ch_cnt    <= '0;
      end else if (shift_en) begin
        shift_reg <= shift_nxt;
        bit_cnt   <= word_end ? '0 : bit_cnt + 1'b1;
        if (word_end) ch_cnt <= ch_cnt + 1'b1;
      end
    end
  // a full FIFO still accepts a push when the head is popped at the same edge
  always_comb begin
    full  = count == CNT_W'(FIFO_DEPTH);
    pop   = out_valid && out_ready;
    wr_en = word_end && (!full || pop);
  end
  always_ff @(posedge serial_clk or negedge reset)
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= {shift_nxt, ch_cnt};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(wr_en) - CNT_W'(pop);
      if (word_end && full && !pop) overflow <= 1'b1;
    end
  assign {out_data, out_ch} = mem[rd_ptr];
  assign out_valid     = count != '0;
  assign fifo_count    = count;
  assign shift_reg_out = shift_reg;
endmodule

// File: tb/tb_spi_frame_receiver.sv
// tb_spi_frame_receiver: directed scenario tests for spi_frame_receiver (MSB-first stereo and LSB-first mono instances).
module tb_spi_frame_receiver;
  logic serial_clk = 1'b0, reset = 1'b1, chip_select = 1'b1, mosi = 1'b0, out_ready = 1'b1;
  logic [15:0] out_data, shift_reg_out;
  logic out_ch, out_valid, frame_done, frame_err, overflow;
  logic [2:0] fifo_count;
  logic cs2 = 1'b1, mosi2 = 1'b0, ready2 = 1'b0;
  logic [15:0] data2, sr2;
  logic ch2, valid2, done2, err2, ovf2;
  logic [2:0] cnt2;
  int checks = 0, failures = 0, done_cnt = 0, err_cnt = 0;
  logic [16:0] got[$];
  logic [15:0] ow [0:5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};

  spi_frame_receiver u_dut (
    .serial_clk(serial_clk), .reset(reset), .chip_select(chip_select), .mosi(mosi),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
    .shift_reg_out(shift_reg_out), .fifo_count(fifo_count), .frame_done(frame_done),
    .frame_err(frame_err), .overflow(overflow));

  spi_frame_receiver #(.NUM_CH(1), .MSB_FIRST(0)) u_lsb (
    .serial_clk(serial_clk), .reset(reset), .chip_select(cs2), .mosi(mosi2),
    .out_data(data2), .out_ch(ch2), .out_valid(valid2), .out_ready(ready2),
    .shift_reg_out(sr2), .fifo_count(cnt2), .frame_done(done2),
    .frame_err(err2), .overflow(ovf2));

  always #5 serial_clk = ~serial_clk;

  always @(negedge serial_clk) begin
    if (out_valid && out_ready) got.push_back({out_ch, out_data});
    if (frame_done) done_cnt++;
    if (frame_err) err_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic c, input logic m);
    chip_select = c;
    mosi = m;
    @(posedge serial_clk);
    #2;
  endtask

  task automatic drive2(input logic c, input logic m);
    cs2 = c;
    mosi2 = m;
    @(posedge serial_clk);
    #2;
  endtask

  task automatic send_word(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, w[15-i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0);
  endtask

  task automatic clear_log();
    got.delete();
    done_cnt = 0;
    err_cnt = 0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (shift_reg_out !== 16'h0) begin failures++; $display("FAIL reset_shift got=%h exp=0000", shift_reg_out); end
    checks++; if ({frame_done, frame_err, overflow} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {frame_done, frame_err, overflow}); end
    checks++; if ({out_ch, out_data} !== 17'h0) begin failures++; $display("FAIL reset_head got=%h exp=0", {out_ch, out_data}); end
    @(posedge serial_clk);
    #2 reset = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    clear_log();
    send_word(16'hA5A5, 16);
    @(negedge serial_clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 16'hA5A5 || out_ch !== 1'b0) begin failures++; $display("FAIL basic_latency got=%b/%h/%b exp=1/a5a5/0", out_valid, out_data, out_ch); end
    checks++; if (shift_reg_out !== 16'hA5A5) begin failures++; $display("FAIL basic_shift got=%h exp=a5a5", shift_reg_out); end
    send_word(16'h3C0F, 16);
    drive(1'b1, 1'b0);
    @(negedge serial_clk);
    checks++; if (frame_done !== 1'b1 || frame_err !== 1'b0) begin failures++; $display("FAIL basic_pulse got=%b%b exp=10", frame_done, frame_err); end
    idle(3);
    checks++; if (got.size() !== 2) begin failures++; $display("FAIL basic_words got=%0d exp=2", got.size()); end
    checks++; if (got[0] !== 17'h0A5A5) begin failures++; $display("FAIL basic_w0 got=%h exp=0a5a5", got[0]); end
    checks++; if (got[1] !== 17'h13C0F) begin failures++; $display("FAIL basic_w1 got=%h exp=13c0f", got[1]); end
    checks++; if (done_cnt !== 1 || err_cnt !== 0) begin failures++; $display("FAIL basic_counts got=%0d/%0d exp=1/0", done_cnt, err_cnt); end
  endtask

  task automatic test_frame_err();
    clear_log();
    send_word(16'hA5A5, 16);
    send_word(16'h3C0F, 8);
    drive(1'b1, 1'b0);
    @(negedge serial_clk);
    checks++; if (frame_err !== 1'b1 || frame_done !== 1'b0) begin failures++; $display("FAIL err_pulse got=%b%b exp=10", frame_err, frame_done); end
    idle(2);
    checks++; if (got.size() !== 1 || got[0] !== 17'h0A5A5) begin failures++; $display("FAIL err_words got=%0d/%h exp=1/0a5a5", got.size(), got[0]); end
    checks++; if (err_cnt !== 1 || done_cnt !== 0) begin failures++; $display("FAIL err_counts got=%0d/%0d exp=1/0", err_cnt, done_cnt); end
    send_word(16'h1111, 16);
    send_word(16'h2222, 16);
    drive(1'b1, 1'b0);
    idle(2);
    checks++; if (got.size() !== 3 || got[1] !== 17'h01111 || got[2] !== 17'h12222) begin failures++; $display("FAIL err_recover got=%0d/%h/%h exp=3/01111/12222", got.size(), got[1], got[2]); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL err_recover_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    clear_log();
    send_word(16'h1234, 16);
    send_word(16'h5678, 16);
    drive(1'b1, 1'b0);
    send_word(16'h9ABC, 16);
    send_word(16'hDEF0, 16);
    drive(1'b1, 1'b0);
    idle(2);
    checks++; if (got.size() !== 4) begin failures++; $display("FAIL b2b_words got=%0d exp=4", got.size()); end
    checks++; if (got[2] !== 17'h09ABC || got[3] !== 17'h1DEF0) begin failures++; $display("FAIL b2b_second got=%h/%h exp=09abc/1def0", got[2], got[3]); end
    checks++; if (done_cnt !== 2 || err_cnt !== 0) begin failures++; $display("FAIL b2b_counts got=%0d/%0d exp=2/0", done_cnt, err_cnt); end
  endtask

  task automatic test_excess();
    clear_log();
    send_word(16'hA5A5, 16);
    send_word(16'h3C0F, 16);
    send_word(16'hFF00, 8);
    @(negedge serial_clk);
    checks++; if (shift_reg_out !== 16'h3C0F) begin failures++; $display("FAIL excess_hold got=%h exp=3c0f", shift_reg_out); end
    checks++; if (got.size() !== 2 || fifo_count !== 3'd0) begin failures++; $display("FAIL excess_words got=%0d/%0d exp=2/0", got.size(), fifo_count); end
    drive(1'b1, 1'b0);
    @(negedge serial_clk);
    checks++; if (frame_done !== 1'b1 || shift_reg_out !== 16'h0) begin failures++; $display("FAIL excess_close got=%b/%h exp=1/0000", frame_done, shift_reg_out); end
  endtask

  task automatic test_overflow();
    clear_log();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      send_word(ow[2*k], 16);
      send_word(ow[2*k+1], 16);
      drive(1'b1, 1'b0);
      if (k == 1) begin
        @(negedge serial_clk);
        checks++; if (fifo_count !== 3'd4 || overflow !== 1'b0) begin failures++; $display("FAIL ovf_full got=%0d/%b exp=4/0", fifo_count, overflow); end
      end
    end
    @(negedge serial_clk);
    checks++; if (fifo_count !== 3'd4 || overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%0d/%b exp=4/1", fifo_count, overflow); end
    checks++; if (out_data !== 16'h1111 || out_ch !== 1'b0 || got.size() !== 0) begin failures++; $display("FAIL ovf_head got=%h/%b/%0d exp=1111/0/0", out_data, out_ch, got.size()); end
    drive(1'b1, 1'b0);
    out_ready = 1'b1;
    idle(6);
    checks++; if (got.size() !== 4) begin failures++; $display("FAIL ovf_drain got=%0d exp=4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got[i] !== {i[0], ow[i]}) begin failures++; $display("FAIL ovf_order%0d got=%h exp=%h", i, got[i], {i[0], ow[i]}); end
    end
    checks++; if (fifo_count !== 3'd0 || overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0d/%b exp=0/1", fifo_count, overflow); end
  endtask

  task automatic test_async_reset();
    clear_log();
    out_ready = 1'b0;
    send_word(16'h1111, 16);
    send_word(16'h2222, 16);
    drive(1'b1, 1'b0);
    send_word(16'hFFFF, 5);
    #1 reset = 1'b0;
    #1;
    checks++; if (fifo_count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL areset_fifo got=%0d/%b exp=0/0", fifo_count, out_valid); end
    checks++; if (overflow !== 1'b0 || shift_reg_out !== 16'h0) begin failures++; $display("FAIL areset_state got=%b/%h exp=0/0000", overflow, shift_reg_out); end
    #1 reset = 1'b1;
    out_ready = 1'b1;
    clear_log();
    send_word(16'hFFFF, 16);
    send_word(16'hF0F0, 4);
    @(negedge serial_clk);
    checks++; if (fifo_count !== 3'd0 || shift_reg_out !== 16'h0 || got.size() !== 0) begin failures++; $display("FAIL areset_wait got=%0d/%h/%0d exp=0/0000/0", fifo_count, shift_reg_out, got.size()); end
    checks++; if (done_cnt !== 0 || err_cnt !== 0) begin failures++; $display("FAIL areset_pulses got=%0d/%0d exp=0/0", done_cnt, err_cnt); end
    drive(1'b1, 1'b0);
    send_word(16'hAAAA, 16);
    send_word(16'h5555, 16);
    drive(1'b1, 1'b0);
    idle(2);
    checks++; if (got.size() !== 2 || got[0] !== 17'h0AAAA || got[1] !== 17'h15555) begin failures++; $display("FAIL areset_frame got=%0d/%h/%h exp=2/0aaaa/15555", got.size(), got[0], got[1]); end
    checks++; if (done_cnt !== 1 || err_cnt !== 0) begin failures++; $display("FAIL areset_counts got=%0d/%0d exp=1/0", done_cnt, err_cnt); end
  endtask

  task automatic test_lsb_first();
    logic [15:0] w;
    w = 16'hA5A5;
    for (int i = 0; i < 16; i++) drive2(1'b0, w[i]);
    @(negedge serial_clk);
    checks++; if (valid2 !== 1'b1 || data2 !== 16'hA5A5 || ch2 !== 1'b0) begin failures++; $display("FAIL lsb_word got=%b/%h/%b exp=1/a5a5/0", valid2, data2, ch2); end
    checks++; if (cnt2 !== 3'd1) begin failures++; $display("FAIL lsb_count got=%0d exp=1", cnt2); end
    drive2(1'b1, 1'b0);
    @(negedge serial_clk);
    checks++; if (done2 !== 1'b1 || err2 !== 1'b0) begin failures++; $display("FAIL lsb_pulse got=%b%b exp=10", done2, err2); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frame_err();
    test_back_to_back();
    test_excess();
    test_overflow();
    test_async_reset();
    test_lsb_first();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_frame_receiver.md
# spi_frame_receiver

Parametrised successor to the single-word SPI receiver, clocked directly by the free-running `serial_clk`. Receives framed multi-channel words on `mosi` while `chip_select` is low, for example stereo L/R audio samples. Each word is tagged with its channel index and buffered in a small FIFO with a ready/valid read port. Reports frame completion, short-frame errors and FIFO overflow to the audio processing datapath.

## Interface
- `DATA_W`, 16, bits per word (≥2)
- `NUM_CH`, 2, words per frame (≥1)
- `FIFO_DEPTH`, 4, output FIFO entries (power of 2, ≥2)
- `MSB_FIRST`, 1, 1: first bit on the wire is word MSB; 0: first bit is LSB
- Derived: `CH_W` = max(1, $clog2(NUM_CH)); `CNT_W` = $clog2(FIFO_DEPTH)+1
- `serial_clk`  in  1  sole clock; free-running; all sampling on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `chip_select`  in  1  active-low frame enable
- `mosi`  in  1  serial data, valid at rising edges where `chip_select`=0
- `out_data`  out  DATA_W  FIFO head word
- `out_ch`  out  CH_W  channel index of the head word (0 = first word of frame)
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  consumer accept; a pop occurs at an edge with `out_valid`&`out_ready`
- `shift_reg_out`  out  DATA_W  live shift register (debug)
- `fifo_count`  out  CNT_W  current FIFO occupancy
- `frame_done`  out  1  one-cycle pulse: full frame received and closed
- `frame_err`  out  1  one-cycle pulse: frame closed short
- `overflow`  out  1  sticky: a completed word was dropped

## Operation
- Reset values: all outputs 0, FIFO empty, `bit_cnt`=0, `ch_cnt`=0, state WAIT.
- States and transitions:
  - WAIT: ignores all bits. Goes to IDLE at the first edge that samples `chip_select`=1. This prevents joining a frame mid-stream after reset.
  - IDLE: an edge that samples `chip_select`=0 captures that edge's `mosi` as bit 0 of channel 0 and goes to RECV.
  - RECV: each edge with `chip_select`=0 shifts in one bit.
    - MSB_FIRST=1: `shift_reg` ← {`shift_reg`[DATA_W-2:0], `mosi`}.
    - MSB_FIRST=0: `shift_reg` ← {`mosi`, `shift_reg`[DATA_W-1:1]}.
    - When the bit completes a word (`bit_cnt`=DATA_W-1), push {next `shift_reg` value, `ch_cnt`} to the FIFO, then set `bit_cnt`←0 and `ch_cnt`←`ch_cnt`+1.
    - After word NUM_CH-1 is pushed, go to DONE.
  - DONE: further bits are ignored; nothing is pushed and `shift_reg` is held.
- Frame close, at an edge sampling `chip_select`=1:
  - From DONE: pulse `frame_done`, go to IDLE.
  - From RECV with `bit_cnt`>0 or `ch_cnt`>0: pulse `frame_err` and discard the partial word. Words already pushed remain in the FIFO. Go to IDLE.
  - From RECV with nothing received: go to IDLE with no pulse.
  - On any close: `shift_reg`, `bit_cnt` and `ch_cnt` clear to 0.
- FIFO:
  - Circular buffer with wrapping read/write pointers.
  - Push when full with no pop at the same edge: drop the word and set `overflow`=1 until reset. FIFO contents are unchanged.
  - Push when full with a pop at the same edge: accepted, occupancy stays FIFO_DEPTH.
  - Pop when empty: ignored.
  - Simultaneous push and pop on a non-empty FIFO: `fifo_count` unchanged.

## Timing
- Word latency: the word is present on `out_data`/`out_ch` with `out_valid`=1 in the cycle after the edge that sampled its last bit, provided the FIFO was empty.
- `out_data`/`out_ch` change only after a pop or after a push into an empty FIFO. They are undefined-but-stable when `out_valid`=0, and show the last read-position contents.
- `frame_done`/`frame_err`: high for exactly one cycle following the closing edge. They are mutually exclusive.
- `shift_reg_out` reflects the register after each edge.
- Back-to-back frames: `chip_select` high for a single sampled edge is a valid inter-frame gap.
- An asynchronous `reset` assertion mid-frame immediately clears all state and the FIFO. After release the block sits in WAIT.

## Test plan
- Defaults, `out_ready`=1. Frame 0xA5A5 then 0x3C0F, MSB first, then `chip_select` high → two outputs: (ch0, 0xA5A5) then (ch1, 0x3C0F). `frame_done` pulses once, `frame_err` stays 0.
- Same frame but `chip_select` rises after 8 bits of word 1 → only (ch0, 0xA5A5) is output and `frame_err` pulses once. The next full frame starts at ch0.
- Frame of 40 bits → exactly two words, the 8 excess bits are ignored, `shift_reg_out` holds 0x3C0F until close, then `frame_done` pulses.
- `out_ready`=0, 3 frames (6 words) → `fifo_count`=4 and `overflow`=1 from the 5th word. Setting `out_ready`=1 then drains the first 4 words in order with correct `out_ch`.
- MSB_FIRST=0, NUM_CH=1, bits of 0xA5A5 sent LSB first → `out_data`=0xA5A5.
- Assert `reset` after 5 bits, release with `chip_select` still low, send 20 more bits → no push, no pulses. After `chip_select` goes high and a new frame is sent, outputs are correct.
